regfile_param: RTL and testbench

Parametrised special-purpose register file for the 16-bit stack machine. It is the generalised successor of the fixed nine-register file, with configurable width and depth, and a dedicated return-address (RA) write path. It adds a registered read port with a valid strobe, same-cycle write-through, and a hardware increment/decrement port for pointer registers such as the stack pointer. It also adds a sticky address-error flag. It sits between the control unit/datapath and the ALU/memory address logic.

---
 rtl/regfile_param.sv | 71 +++++++
 tb/tb_regfile_param.sv | 128 ++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// regfile_param: parametrised register file with RA write path, write-first registered read, inc/dec port and sticky address error
module regfile_param #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 9,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             ra_we,
    input  logic [WIDTH-1:0] ra_din,
    output logic [WIDTH-1:0] ra_dout,
    input  logic             inc_en,
    input  logic [AW-1:0]    inc_addr,
    input  logic             inc_dn,
    output logic             addr_err
);
    localparam logic [AW:0]    DEPTH_L = DEPTH[AW:0];
    localparam logic [WIDTH-1:0] ONE   = 1;

    logic [WIDTH-1:0] regs [DEPTH];
    logic [WIDTH-1:0] nxt  [DEPTH];
    logic [WIDTH-1:0] rd_next;
    logic             wsel, isel;
    logic             wr_oor, inc_oor, rd_oor;

    assign wr_oor  = wr_en  && ({1'b0, wr_addr}  >= DEPTH_L);
    assign inc_oor = inc_en && ({1'b0, inc_addr} >= DEPTH_L);
    assign rd_oor  = rd_en  && ({1'b0, rd_addr}  >= DEPTH_L);
    assign ra_dout = regs[0];

    // Per-register next value; RA port only exists on index 0
    always_comb begin
        wsel = 1'b0;
        isel = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wsel   = wr_en  && (wr_addr  == AW'(i));
            isel   = inc_en && (inc_addr == AW'(i));
            nxt[i] = (i == 0 && ra_we) ? ra_din :
                     wsel ? wr_data :
                     isel ? (inc_dn ? regs[i] - ONE : regs[i] + ONE) : regs[i];
        end
    end

    // Reads see this edge's update; unmatched (out-of-range) index yields 0
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < DEPTH; i++)
            if (rd_addr == AW'(i)) rd_next = nxt[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= nxt[i];
            rd_data  <= rd_en ? rd_next : rd_data;
            rd_valid <= rd_en;
            addr_err <= addr_err | wr_oor | inc_oor | rd_oor;
        end
    end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: vector table plus read-data scoreboard for regfile_param
module tb_regfile_param;
    logic        clk = 0, reset = 0;
    logic        rd_en = 0, wr_en = 0, ra_we = 0, inc_en = 0, inc_dn = 0;
    logic [3:0]  rd_addr = 0, wr_addr = 0, inc_addr = 0;
    logic [15:0] wr_data = 0, ra_din = 0;
    logic [15:0] rd_data, ra_dout;
    logic        rd_valid, addr_err;

    regfile_param #(.WIDTH(16), .DEPTH(9), .AW(4)) dut (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ra_we(ra_we), .ra_din(ra_din), .ra_dout(ra_dout), .inc_en(inc_en),
        .inc_addr(inc_addr), .inc_dn(inc_dn), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, re;
        logic [3:0]  raddr;
        logic        we;
        logic [3:0]  waddr;
        logic [15:0] wdata;
        logic        raw;
        logic [15:0] rad;
        logic        ie;
        logic [3:0]  iaddr;
        logic        idn;
        logic [15:0] erd, era;
        logic        eerr;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] sb[$];
    int          n_checks = 0, n_fail = 0;

    function automatic vec_t mk(input logic rst, re, input logic [3:0] raddr, input logic we,
                                input logic [3:0] waddr, input logic [15:0] wdata, input logic raw,
                                input logic [15:0] rad, input logic ie, input logic [3:0] iaddr,
                                input logic idn, input logic [15:0] erd, era, input logic eerr);
        vec_t v;
        v.rst = rst; v.re = re; v.raddr = raddr; v.we = we; v.waddr = waddr; v.wdata = wdata;
        v.raw = raw; v.rad = rad; v.ie = ie; v.iaddr = iaddr; v.idn = idn;
        v.erd = erd; v.era = era; v.eerr = eerr;
        return v;
    endfunction

    function automatic vec_t rd(input logic [3:0] a, input logic [15:0] e, era, input logic err);
        return mk(0, 1, a, 0, 0, 0, 0, 0, 0, 0, 0, e, era, err);
    endfunction

    function automatic vec_t wr(input logic [3:0] a, input logic [15:0] d, era, input logic err);
        return mk(0, 0, 0, 1, a, d, 0, 0, 0, 0, 0, 0, era, err);
    endfunction

    task automatic check(input string name, input logic [15:0] act, exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        reset = v.rst; rd_en = v.re; rd_addr = v.raddr; wr_en = v.we; wr_addr = v.waddr;
        wr_data = v.wdata; ra_we = v.raw; ra_din = v.rad; inc_en = v.ie; inc_addr = v.iaddr;
        inc_dn = v.idn;
        if (v.re && !v.rst) sb.push_back(v.erd);
        @(posedge clk);
        #1;
        check("rd_valid", {15'b0, rd_valid}, {15'b0, v.re && !v.rst});
        if (rd_valid) begin
            if (sb.size() == 0) check("sb_underflow", 16'd1, 16'd0);
            else check("rd_data", rd_data, sb.pop_front());
        end
        check("ra_dout", ra_dout, v.era);
        check("addr_err", {15'b0, addr_err}, {15'b0, v.eerr});
    endtask

    initial begin
        // reset with a read pending, then read every index
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 9; k++) tbl.push_back(rd(4'(k), 16'h0, 16'h0, 0));
        for (int k = 1; k < 9; k++) tbl.push_back(wr(4'(k), 16'(16'h1111 * k), 16'h0, 0));
        for (int k = 1; k < 9; k++) tbl.push_back(rd(4'(k), 16'(16'h1111 * k), 16'h0, 0));
        // RA port beats general write and inc on register 0
        tbl.push_back(mk(0, 1, 0, 1, 0, 16'h1234, 1, 16'hBEEF, 1, 0, 0, 16'hBEEF, 16'hBEEF, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 16'h1234, 0, 0, 0, 0, 0, 16'h1234, 16'h1234, 0));
        // inc/dec wrap on index 3
        tbl.push_back(wr(3, 16'hFFFE, 16'h1234, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 16'h1234, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 0, 16'h0000, 16'h1234, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 1, 3, 1, 16'hFFFF, 16'h1234, 0));
        tbl.push_back(mk(0, 1, 3, 1, 3, 16'h0042, 0, 0, 1, 3, 0, 16'h0042, 16'h1234, 0));
        // RA, write and inc to three registers in one cycle
        tbl.push_back(mk(0, 0, 0, 1, 2, 16'h7777, 1, 16'h0A0A, 1, 4, 0, 0, 16'h0A0A, 0));
        tbl.push_back(rd(2, 16'h7777, 16'h0A0A, 0));
        tbl.push_back(rd(4, 16'h4445, 16'h0A0A, 0));
        // write-first read
        tbl.push_back(mk(0, 1, 5, 1, 5, 16'h5A5A, 0, 0, 0, 0, 0, 16'h5A5A, 16'h0A0A, 0));
        tbl.push_back(wr(5, 16'h0007, 16'h0A0A, 0));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 1, 5, 0, 16'h0008, 16'h0A0A, 0));
        // out of range: ignored write/inc, zero read, sticky flag
        tbl.push_back(wr(12, 16'hDEAD, 16'h0A0A, 1));
        tbl.push_back(rd(9, 16'h0000, 16'h0A0A, 1));
        tbl.push_back(mk(0, 1, 8, 0, 0, 0, 0, 0, 1, 15, 0, 16'h8888, 16'h0A0A, 1));
        tbl.push_back(rd(1, 16'h1111, 16'h0A0A, 1));
        tbl.push_back(rd(3, 16'h0042, 16'h0A0A, 1));
        // reset mid-read clears everything and suppresses rd_valid
        tbl.push_back(mk(1, 1, 5, 1, 5, 16'hFFFF, 1, 16'hFFFF, 0, 0, 0, 0, 16'h0, 0));
        tbl.push_back(rd(5, 16'h0, 16'h0, 0));
        tbl.push_back(rd(8, 16'h0, 16'h0, 0));

        foreach (tbl[i]) apply(tbl[i]);

        // same register incremented every cycle while being read back-to-back
        apply(wr(6, 16'h0010, 16'h0, 0));
        for (int k = 1; k <= 4; k++)
            apply(mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 6, 0, 16'(16'h0010 + k), 16'h0, 0));
        apply(mk(0, 1, 6, 0, 0, 0, 0, 0, 1, 6, 1, 16'h0013, 16'h0, 0));
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 0));

        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
